// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry in-order retirement reorder buffer with rollback
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    output logic                 rob_full,
    input  logic                 issue,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd,
    input  logic [31:0]          issue_pc,
    input  logic                 issue_pred_jump,
    input  logic                 issue_ready,
    input  logic [31:0]          issue_val,
    output logic [ROB_WIDTH-1:0] issue_rob_pos,
    input  logic                 alu_valid,
    input  logic [ROB_WIDTH-1:0] alu_rob_pos,
    input  logic [31:0]          alu_val,
    input  logic                 alu_real_jump,
    input  logic [31:0]          alu_target,
    input  logic                 lsb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_rob_pos,
    input  logic [31:0]          lsb_val,
    input  logic [ROB_WIDTH-1:0] q1_pos,
    output logic                 q1_ready,
    output logic [31:0]          q1_val,
    input  logic [ROB_WIDTH-1:0] q2_pos,
    output logic                 q2_ready,
    output logic [31:0]          q2_val,
    output logic                 commit,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_rob_pos,
    output logic                 commit_store,
    output logic [ROB_WIDTH-1:0] commit_store_pos,
    output logic                 rollback,
    output logic [31:0]          rollback_pc
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    typedef logic [ROB_WIDTH-1:0] ptr_t;
    typedef logic [ROB_WIDTH:0]   cnt_t;

    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [DEPTH-1:0] pred_jump_q, pred_jump_d, real_jump_q, real_jump_d;
    logic [1:0]       type_q [DEPTH];
    logic [1:0]       type_d [DEPTH];
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       rd_d [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic [31:0]      val_d [DEPTH];
    logic [31:0]      pc_q [DEPTH];
    logic [31:0]      pc_d [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];
    ptr_t             head_q, head_d, tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic             commit_q, commit_d, commit_store_q, commit_store_d;
    logic             rollback_q, rollback_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_val_q, commit_val_d, rollback_pc_q, rollback_pc_d;
    ptr_t             commit_rob_pos_q, commit_rob_pos_d;
    ptr_t             commit_store_pos_q, commit_store_pos_d;

    logic issue_ok, retire, mispredict;

    assign rob_full   = (count_q == cnt_t'(DEPTH));
    assign issue_ok   = issue && !rob_full && !rollback_q;
    assign retire     = (count_q != '0) && ready_q[head_q];
    assign mispredict = retire && (type_q[head_q] == TYPE_BRANCH)
                        && (real_jump_q[head_q] != pred_jump_q[head_q]);

    // Next-state: allocate at tail, apply both result buses, retire head, flush on mispredict
    always_comb begin
        busy_d = busy_q;  ready_d = ready_q;
        pred_jump_d = pred_jump_q;  real_jump_d = real_jump_q;
        type_d = type_q;  rd_d = rd_q;  val_d = val_q;  pc_d = pc_q;  target_d = target_q;
        head_d = head_q;  tail_d = tail_q;  count_d = count_q;
        commit_d = commit_q;  commit_rd_d = commit_rd_q;  commit_val_d = commit_val_q;
        commit_rob_pos_d = commit_rob_pos_q;
        commit_store_d = commit_store_q;  commit_store_pos_d = commit_store_pos_q;
        rollback_d = rollback_q;  rollback_pc_d = rollback_pc_q;
        if (rdy) begin
            commit_d = 1'b0;
            commit_store_d = 1'b0;
            rollback_d = 1'b0;
            if (issue_ok) begin
                busy_d[tail_q]      = 1'b1;
                ready_d[tail_q]     = issue_ready;
                type_d[tail_q]      = issue_type;
                rd_d[tail_q]        = issue_rd;
                pc_d[tail_q]        = issue_pc;
                val_d[tail_q]       = issue_val;
                pred_jump_d[tail_q] = issue_pred_jump;
                real_jump_d[tail_q] = 1'b0;
                tail_d              = tail_q + ptr_t'(1);
            end
            if (alu_valid && busy_q[alu_rob_pos]) begin
                ready_d[alu_rob_pos]     = 1'b1;
                val_d[alu_rob_pos]       = alu_val;
                real_jump_d[alu_rob_pos] = alu_real_jump;
                target_d[alu_rob_pos]    = alu_target;
            end
            if (lsb_valid && busy_q[lsb_rob_pos]) begin
                ready_d[lsb_rob_pos] = 1'b1;
                val_d[lsb_rob_pos]   = lsb_val;
            end
            if (retire) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + ptr_t'(1);
                // Branches with a nonzero rd carry a link address that must reach the register file
                if (type_q[head_q] == TYPE_REG ||
                    (type_q[head_q] == TYPE_BRANCH && rd_q[head_q] != 5'd0)) begin
                    commit_d         = 1'b1;
                    commit_rd_d      = rd_q[head_q];
                    commit_val_d     = val_q[head_q];
                    commit_rob_pos_d = head_q;
                end
                if (type_q[head_q] == TYPE_STORE) begin
                    commit_store_d     = 1'b1;
                    commit_store_pos_d = head_q;
                end
                if (mispredict) begin
                    rollback_d    = 1'b1;
                    rollback_pc_d = real_jump_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
                end
            end
            case ({issue_ok, retire})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
            if (mispredict) begin
                busy_d  = '0;
                ready_d = '0;
                tail_d  = head_q + ptr_t'(1);
                count_d = '0;
            end
        end
    end

    // Control state and output pulse registers, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;  ready_q <= '0;
            head_q <= '0;  tail_q <= '0;  count_q <= '0;
            commit_q <= 1'b0;  commit_rd_q <= '0;  commit_val_q <= '0;  commit_rob_pos_q <= '0;
            commit_store_q <= 1'b0;  commit_store_pos_q <= '0;
            rollback_q <= 1'b0;  rollback_pc_q <= '0;
        end else begin
            busy_q <= busy_d;  ready_q <= ready_d;
            head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
            commit_q <= commit_d;  commit_rd_q <= commit_rd_d;  commit_val_q <= commit_val_d;
            commit_rob_pos_q <= commit_rob_pos_d;
            commit_store_q <= commit_store_d;  commit_store_pos_q <= commit_store_pos_d;
            rollback_q <= rollback_d;  rollback_pc_q <= rollback_pc_d;
        end
    end

    // Entry payload; only meaningful while busy, so it needs no reset
    always_ff @(posedge clk) begin
        pred_jump_q <= pred_jump_d;  real_jump_q <= real_jump_d;
        type_q <= type_d;  rd_q <= rd_d;  val_q <= val_d;  pc_q <= pc_d;  target_q <= target_d;
    end

    // Operand query 1: stored result first, then same-cycle ALU, then LSB forwarding
    always_comb begin
        q1_ready = 1'b0;
        q1_val   = '0;
        if (ready_q[q1_pos]) begin
            q1_ready = 1'b1;  q1_val = val_q[q1_pos];
        end else if (alu_valid && alu_rob_pos == q1_pos) begin
            q1_ready = 1'b1;  q1_val = alu_val;
        end else if (lsb_valid && lsb_rob_pos == q1_pos) begin
            q1_ready = 1'b1;  q1_val = lsb_val;
        end
    end

    // Operand query 2: same priority as query 1
    always_comb begin
        q2_ready = 1'b0;
        q2_val   = '0;
        if (ready_q[q2_pos]) begin
            q2_ready = 1'b1;  q2_val = val_q[q2_pos];
        end else if (alu_valid && alu_rob_pos == q2_pos) begin
            q2_ready = 1'b1;  q2_val = alu_val;
        end else if (lsb_valid && lsb_rob_pos == q2_pos) begin
            q2_ready = 1'b1;  q2_val = lsb_val;
        end
    end

    assign issue_rob_pos    = tail_q;
    assign commit           = commit_q;
    assign commit_rd        = commit_rd_q;
    assign commit_val       = commit_val_q;
    assign commit_rob_pos   = commit_rob_pos_q;
    assign commit_store     = commit_store_q;
    assign commit_store_pos = commit_store_pos_q;
    assign rollback         = rollback_q;
    assign rollback_pc      = rollback_pc_q;
endmodule
